// File: rtl/mirfak_clint.sv
// Core-local interruptor: 64-bit machine timer with compare, plus software-interrupt bit.
// Wishbone B4 classic slave; interrupt outputs feed mip.MTIP / mip.MSIP in the CSR unit.
module mirfak_clint #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_msip_o,
  output logic        xint_mtip_o
);

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_sel_e;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] presc_q, presc_d;
  logic        msip_q, msip_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic        mtip_q, mtip_d;
  logic        msip_o_q, msip_o_d;

  logic        req;
  logic        wr;
  logic        tick;
  reg_sel_e    reg_sel;
  logic [31:0] rd_data;
  logic [15:0] word_addr;
  logic        unused_addr;

  assign unused_addr = ^wbs_addr_i[1:0];
  assign word_addr   = {wbs_addr_i[15:2], 2'b00};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode and read mux, both on pre-edge register values.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    reg_sel = REG_NONE;
    rd_data = 32'h0;
    unique case (word_addr)
      16'h0000: reg_sel = REG_MSIP;
      16'h4000: reg_sel = REG_CMP_LO;
      16'h4004: reg_sel = REG_CMP_HI;
      16'hBFF8: reg_sel = REG_TIME_LO;
      16'hBFFC: reg_sel = REG_TIME_HI;
      default:  reg_sel = REG_NONE;
    endcase
    unique case (reg_sel)
      REG_MSIP:    rd_data = {31'h0, msip_q};
      REG_CMP_LO:  rd_data = mtimecmp_q[31:0];
      REG_CMP_HI:  rd_data = mtimecmp_q[63:32];
      REG_TIME_LO: rd_data = mtime_q[31:0];
      REG_TIME_HI: rd_data = mtime_q[63:32];
      default:     rd_data = 32'h0;
    endcase
  end

  always_comb begin
    req  = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
    wr   = req & wbs_we_i & (reg_sel != REG_NONE);
    tick = (presc_q == PRESC_MAX);

    ack_d = req & (reg_sel != REG_NONE);
    err_d = req & (reg_sel == REG_NONE);
    dat_d = ack_d ? rd_data : 32'h0;

    presc_d    = tick ? 16'h0 : presc_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;

    // A write to one mtime half replaces that cycle's tick; the other half holds, no carry.
    if (wr) begin
      unique case (reg_sel)
        REG_MSIP:    if (wbs_sel_i[0]) msip_d = wbs_dat_i[0];
        REG_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wbs_dat_i, wbs_sel_i);
        REG_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wbs_dat_i, wbs_sel_i);
        REG_TIME_LO: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wbs_dat_i, wbs_sel_i)};
        REG_TIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], wbs_dat_i, wbs_sel_i), mtime_q[31:0]};
        default: ;
      endcase
    end

    mtip_d   = (mtime_q >= mtimecmp_q);
    msip_o_d = msip_q;
  end

  // NOTE: state updates use non-blocking assignments; every flop here is a plain register, so all get a reset value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_q    <= 16'h0;
      msip_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= 32'h0;
      mtip_q     <= 1'b0;
      msip_o_q   <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      msip_q     <= msip_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      mtip_q     <= mtip_d;
      msip_o_q   <= msip_o_d;
    end
  end

  assign wbs_dat_o   = dat_q;
  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign xint_mtip_o = mtip_q;
  assign xint_msip_o = msip_o_q;

endmodule
